// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding plus word and byte-offset widths.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int OFF_W  = 2;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 RAM: synchronous write port and registered read port,
// both fired by the controller's commit strobe.
import dmem_responder_pkg::*;

module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata <= '0;
    else if (re)   rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle word data-memory responder behind the EX/MEM register.
// Optional DMEM_MISALIGN_CHECK_EN rejects non-word-aligned requests.
import dmem_responder_pkg::*;

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                op_wr;
  logic                err_pend;
  logic [ADDR_W-1:0]   idx;
  logic [WORD_W-1:0]   wdata;
  logic                req;
  logic                last;
  logic                commit;
  logic                misalign;
  logic                unused_addr;

  assign req    = MemRead_i | MemWrite_i;
  assign last   = (cnt == CNT_W'(LATENCY - 1));
  assign commit = (state == BUSY) && last;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = |addr_i[OFF_W-1:0];
`else
  assign misalign = 1'b0;
`endif

  assign unused_addr = ^{addr_i[31:ADDR_W+OFF_W], addr_i[OFF_W-1:0]};

  // Gated by reset so a held request cannot stall a pipeline in reset
  always_comb begin
    stall_o = 1'b0;
    unique case (state)
      IDLE:    stall_o = req;
      BUSY:    stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
    stall_o = stall_o & rst_n_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      err_pend <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      ready_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr    <= MemWrite_i;
            err_pend <= MemRead_i & MemWrite_i;
            idx      <= addr_i[ADDR_W+OFF_W-1:OFF_W];
            wdata    <= write_data_i;
            cnt      <= '0;
            if (misalign) begin
              state   <= DONE;
              ready_o <= 1'b1;
              err_o   <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state   <= DONE;
            ready_o <= 1'b1;
            err_o   <= err_pend;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we      (commit & op_wr),
    .re      (commit & ~op_wr),
    .addr    (idx),
    .wdata   (wdata),
    .rdata   (read_data_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH 256, LATENCY 2).
// Follows DMEM_MISALIGN_CHECK_EN for the misaligned-access expectations.
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        ready_o;
  logic        stall_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  int          stalls;
  logic [31:0] rdat;
  logic        rerr;

  dmem_responder #(
    .DEPTH   (256),
    .LATENCY (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .read_data_o  (read_data_o),
    .ready_o      (ready_o),
    .stall_o      (stall_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request, counts stall cycles until ready_o, returns data/err
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int ns, output logic [31:0] q,
                        output logic e);
    bit seen;
    seen = 0;
    ns   = 0;
    q    = 'x;
    e    = 1'bx;
    @(negedge clk_i);
    MemRead_i    = rd;
    MemWrite_i   = wr;
    addr_i       = a;
    write_data_i = d;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (ready_o) begin
        q    = read_data_o;
        e    = err_o;
        seen = 1;
        break;
      end
      if (stall_o) ns++;
      @(negedge clk_i);
      #1;
    end
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_err++;
      $error("FAIL timeout: observed no ready_o expected ready_o within 20 cycles");
    end
  endtask

  initial begin
    rst_n_i      = 1'b0;
    MemRead_i    = 1'b0;
    MemWrite_i   = 1'b0;
    addr_i       = '0;
    write_data_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_rdata", read_data_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_ready", {31'b0, ready_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    rst_n_i = 1'b1;

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, stalls, rdat, rerr);
    chk("wr10_stalls", stalls, 32'd3);
    chk("wr10_err", {31'b0, rerr}, 32'h0);
    @(negedge clk_i);
    #1;
    chk("ready_pulse", {31'b0, ready_o}, 32'h0);

    access(1'b1, 1'b0, 32'h10, 32'h0, stalls, rdat, rerr);
    chk("rd10_stalls", stalls, 32'd3);
    chk("rd10_data", rdat, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h400, 32'h12345678, stalls, rdat, rerr);
    chk("wr400_keeps_rdata", rdat, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h0, 32'h0, stalls, rdat, rerr);
    chk("wrap_rd0", rdat, 32'h12345678);

    access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, stalls, rdat, rerr);
    chk("both_err", {31'b0, rerr}, 32'h1);
    chk("both_stalls", stalls, 32'd3);
    chk("both_keeps_rdata", rdat, 32'h12345678);
    access(1'b1, 1'b0, 32'h20, 32'h0, stalls, rdat, rerr);
    chk("rd20_data", rdat, 32'hA5A5A5A5);
    chk("rd20_err", {31'b0, rerr}, 32'h0);

    access(1'b0, 1'b1, 32'h30, 32'h7, stalls, rdat, rerr);
    @(negedge clk_i);
    MemWrite_i   = 1'b1;
    addr_i       = 32'h30;
    write_data_i = 32'h1;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("abort_stall", {31'b0, stall_o}, 32'h0);
    chk("abort_ready", {31'b0, ready_o}, 32'h0);
    @(negedge clk_i);
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    access(1'b1, 1'b0, 32'h30, 32'h0, stalls, rdat, rerr);
    chk("abort_rd30", rdat, 32'h7);

    access(1'b0, 1'b1, 32'h13, 32'h55, stalls, rdat, rerr);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("mis_stalls", stalls, 32'd1);
    chk("mis_err", {31'b0, rerr}, 32'h1);
    access(1'b1, 1'b0, 32'h10, 32'h0, stalls, rdat, rerr);
    chk("mis_word4", rdat, 32'hDEADBEEF);
`else
    chk("mis_stalls", stalls, 32'd3);
    chk("mis_err", {31'b0, rerr}, 32'h0);
    access(1'b1, 1'b0, 32'h10, 32'h0, stalls, rdat, rerr);
    chk("mis_word4", rdat, 32'h55);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits at the far end of the EX/MEM memory-request interface.
- Consumes MemRead/MemWrite, address and write data from the EX/MEM pipeline register.
- Performs a word access with configurable multi-cycle latency.
- Holds the pipeline with a stall signal until the access completes, then returns read data towards MEM/WB.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two.
- LATENCY, 2, BUSY cycles per access; must be at least 1.
- ADDR_W, log2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- MemRead_i  input  1  read request, held stable by the pipeline while stall_o is high.
- MemWrite_i  input  1  write request, held stable while stall_o is high.
- addr_i  input  32  byte address; ALU result.
- write_data_i  input  32  store data.
- read_data_o  output  32  load data; valid when ready_o is high, held until the next completed read.
- ready_o  output  1  one-cycle pulse on access completion.
- stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- err_o  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Clock and reset are fixed: one clock (clk_i); reset rst_n_i is asynchronous and active-low.
- Reset values: state IDLE, counter 0, read_data_o 0, ready_o 0, err_o 0.
- stall_o is combinational and is 0 during reset. Memory contents are not reset.
- Word index is addr_i[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req = MemRead_i | MemWrite_i.
  - stall_o = req.
  - On req: latch operation, index and write data; counter <= 0; go to BUSY.
  - No req: stay in IDLE.
- BUSY:
  - stall_o = 1.
  - Counter increments each cycle.
  - When counter == LATENCY-1:
    - Write: memory[index] <= data.
    - Read: read_data_o <= memory[index].
    - Go to DONE.
- DONE:
  - stall_o = 0, ready_o = 1.
  - Inputs are ignored, because they still carry the completed request.
  - Go to IDLE unconditionally.
- Timing: a request first seen in cycle N completes with ready_o in cycle N+LATENCY+1; stall_o is high for LATENCY+1 cycles.
- Back-to-back memory instructions: each gets its own full sequence. The earliest next request is seen in IDLE one cycle after DONE.
- MemRead_i and MemWrite_i both high: the request is treated as a write. err_o pulses in the DONE cycle.
- Writes do not change read_data_o.
- Reset asserted mid-BUSY: the access is aborted. An uncommitted write is lost, and the state returns to IDLE immediately.
- Latched request fields are used throughout BUSY. Input changes during BUSY have no effect.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, a request with addr_i[1:0] != 0 skips BUSY and goes straight to DONE; stall_o is high for 1 cycle.
  - err_o pulses in DONE.
  - A write is suppressed and read_data_o is unchanged.
- Undefined: addr_i[1:0] is ignored and the access proceeds normally.

Decomposition:
- Shared package contents:
  - state typedef: IDLE / BUSY / DONE.
  - WORD_W = 32.
  - Byte-offset width constant = 2.
- Natural sub-module: dmem_array. It is a DEPTH x 32 RAM with a synchronous write port and a registered read port, driven by the controller's commit strobe.
- Counter, latches and FSM stay in dmem_responder.

Test Plan:
- Reset sequence: rst_n_i low for 3 cycles, no request -> read_data_o = 0, stall_o = 0, ready_o = 0.
- Write then read, LATENCY = 2:
  - Write 0xDEADBEEF to addr 0x10 -> stall_o high for 3 cycles, then ready_o pulse.
  - Read of 0x10 -> read_data_o = 0xDEADBEEF in the ready cycle.
- Wrap, DEPTH = 256:
  - Write 0x12345678 to addr 0x400 -> read of addr 0x0 returns 0x12345678.
- Both MemRead_i and MemWrite_i high with data 0xA5A5A5A5 at addr 0x20 -> err_o pulses with ready_o.
  - Subsequent read of 0x20 returns 0xA5A5A5A5.
- Reset mid-access:
  - Write 0x1 to addr 0x30, after prior contents 0x7.
  - Assert rst_n_i in the first BUSY cycle -> state IDLE, stall_o 0.
  - Later read of 0x30 returns 0x7.
- Misaligned access with DMEM_MISALIGN_CHECK_EN defined: write to addr 0x13 -> stall_o high for 1 cycle, err_o pulse, memory word 4 unchanged.
  - With the macro undefined -> word 4 is written.
